// File: rtl/maxmin_window_if.sv
// Sample-in / statistic-out bundle for the block max/min/range/peak unit.
// The master drives samples and control; the slave returns results and status.
interface maxmin_window_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 4
);

  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic [1:0]       mode;
  logic             clear;
  logic [WIDTH:0]   dout;
  logic [IDX_W-1:0] dout_idx;
  logic             rdy;
  logic             busy;

  modport master (
    output din_valid,
    output din,
    output mode,
    output clear,
    input  dout,
    input  dout_idx,
    input  rdy,
    input  busy
  );

  modport slave (
    input  din_valid,
    input  din,
    input  mode,
    input  clear,
    output dout,
    output dout_idx,
    output rdy,
    output busy
  );

endinterface

// File: rtl/maxmin_window.sv
// Block statistics over BLOCK_LEN valid samples: max, min, range or peak |x|,
// plus the in-block index of the winning sample. Blocks run back-to-back with
// no idle cycle between the last sample of one block and the first of the next.
module maxmin_window #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned BLOCK_LEN = 16,
  parameter int unsigned SIGNED    = 1
) (
  input logic            clk,
  input logic            rst,
  maxmin_window_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BLOCK_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] count_q;
  logic [1:0]       mode_q;

  // Running values are kept in WIDTH+1 bits so signed and unsigned samples share
  // one signed comparator and range/peak never overflow.
  logic [WIDTH:0]   run_max_q;
  logic [WIDTH:0]   run_min_q;
  logic [WIDTH:0]   run_pk_q;
  logic [IDX_W-1:0] max_idx_q;
  logic [IDX_W-1:0] min_idx_q;
  logic [IDX_W-1:0] pk_idx_q;

  logic [WIDTH:0]   dout_q;
  logic [IDX_W-1:0] dout_idx_q;
  logic             rdy_q;
  logic             busy_q;

  logic [WIDTH:0]   sample_ext;
  logic [WIDTH:0]   sample_mag;
  logic [WIDTH:0]   nxt_max;
  logic [WIDTH:0]   nxt_min;
  logic [WIDTH:0]   nxt_pk;
  logic [IDX_W-1:0] nxt_max_idx;
  logic [IDX_W-1:0] nxt_min_idx;
  logic [IDX_W-1:0] nxt_pk_idx;
  logic [WIDTH:0]   result;
  logic [IDX_W-1:0] result_idx;
  logic             is_last;

  // Widen the incoming sample and take its magnitude; -2^(WIDTH-1) maps to +2^(WIDTH-1).
  always_comb begin
    sample_ext = '0;
    sample_mag = '0;
    if (SIGNED != 0) begin
      sample_ext = {bus.din[WIDTH-1], bus.din};
    end else begin
      sample_ext = {1'b0, bus.din};
    end
    if (sample_ext[WIDTH]) begin
      sample_mag = '0 - sample_ext;
    end else begin
      sample_mag = sample_ext;
    end
  end

  // Fold the current sample into the running statistics; strict compares keep
  // the earliest index on ties.
  always_comb begin
    nxt_max     = run_max_q;
    nxt_max_idx = max_idx_q;
    nxt_min     = run_min_q;
    nxt_min_idx = min_idx_q;
    nxt_pk      = run_pk_q;
    nxt_pk_idx  = pk_idx_q;
    if ($signed(sample_ext) > $signed(run_max_q)) begin
      nxt_max     = sample_ext;
      nxt_max_idx = count_q;
    end
    if ($signed(sample_ext) < $signed(run_min_q)) begin
      nxt_min     = sample_ext;
      nxt_min_idx = count_q;
    end
    if (sample_mag > run_pk_q) begin
      nxt_pk     = sample_mag;
      nxt_pk_idx = count_q;
    end
  end

  // Select the statistic for the block using the mode latched at its first sample.
  always_comb begin
    result     = '0;
    result_idx = '0;
    unique case (mode_q)
      2'b00: begin
        result     = nxt_max;
        result_idx = nxt_max_idx;
      end
      2'b01: begin
        result     = nxt_min;
        result_idx = nxt_min_idx;
      end
      2'b10: begin
        result     = nxt_max - nxt_min;
        result_idx = '0;
      end
      2'b11: begin
        result     = nxt_pk;
        result_idx = nxt_pk_idx;
      end
      default: begin
        result     = '0;
        result_idx = '0;
      end
    endcase
  end

  assign is_last = (state_q == StAcc) && (count_q == LAST_IDX);

  // Block FSM with registered result, rdy pulse and busy flag; clear beats everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      mode_q     <= 2'b00;
      run_max_q  <= '0;
      run_min_q  <= '0;
      run_pk_q   <= '0;
      max_idx_q  <= '0;
      min_idx_q  <= '0;
      pk_idx_q   <= '0;
      dout_q     <= '0;
      dout_idx_q <= '0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.clear) begin
        state_q <= StIdle;
        count_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.din_valid) begin
              run_max_q <= sample_ext;
              run_min_q <= sample_ext;
              run_pk_q  <= sample_mag;
              max_idx_q <= '0;
              min_idx_q <= '0;
              pk_idx_q  <= '0;
              mode_q    <= bus.mode;
              count_q   <= IDX_W'(1);
              state_q   <= StAcc;
              busy_q    <= 1'b1;
            end
          end
          StAcc: begin
            if (bus.din_valid) begin
              if (is_last) begin
                dout_q     <= result;
                dout_idx_q <= result_idx;
                rdy_q      <= 1'b1;
                count_q    <= '0;
                state_q    <= StIdle;
                busy_q     <= 1'b0;
              end else begin
                run_max_q <= nxt_max;
                run_min_q <= nxt_min;
                run_pk_q  <= nxt_pk;
                max_idx_q <= nxt_max_idx;
                min_idx_q <= nxt_min_idx;
                pk_idx_q  <= nxt_pk_idx;
                count_q   <= count_q + IDX_W'(1);
              end
            end
          end
          default: begin
            state_q <= StIdle;
            count_q <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_idx = dout_idx_q;
  assign bus.rdy      = rdy_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_maxmin_window.sv
// Directed bench for maxmin_window with default parameters (16-bit signed, 16-sample blocks).
module tb_maxmin_window;

  localparam int unsigned W  = 16;
  localparam int unsigned BL = 16;
  localparam int unsigned IW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   rdy_cnt = 0;

  maxmin_window_if #(.WIDTH(W), .IDX_W(IW)) bus ();

  maxmin_window #(.WIDTH(W), .BLOCK_LEN(BL), .SIGNED(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count rdy pulses away from the active edge.
  always @(negedge clk) if (bus.rdy === 1'b1) rdy_cnt++;

  // Present one input cycle; returns 1 time unit after the edge that samples it.
  task automatic put(input logic v, input int d);
    bus.din_valid = v;
    bus.din       = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.din_valid = 1'b0; bus.din = '0; bus.mode = 2'b00; bus.clear = 1'b0;
    #12;
    n_cmp++;
    if (bus.dout !== 17'd0 || bus.dout_idx !== 4'd0 || bus.rdy !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: dout=%h idx=%0d rdy=%b busy=%b want 0/0/0/0",
               bus.dout, bus.dout_idx, bus.rdy, bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    put(1'b0, 0);
  endtask

  task automatic test_max_min();
    int base;
    for (int pass = 0; pass < 2; pass++) begin
      bus.mode = (pass == 0) ? 2'b00 : 2'b01;
      base = rdy_cnt;
      for (int i = 0; i < 16; i++) begin
        put(1'b1, (i % 2 == 0) ? (i + 1) : -(i + 1));
        if (i == 0) begin
          n_cmp++;
          if (bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_after_first: got %b want 1", bus.busy);
          end
        end
        if (i == 14) begin
          n_cmp++;
          if (bus.rdy !== 1'b0) begin
            n_bad++; $display("FAIL early_rdy: got %b want 0", bus.rdy);
          end
        end
      end
      n_cmp++;
      if (pass == 0 && (bus.rdy !== 1'b1 || bus.dout !== 17'd15 || bus.dout_idx !== 4'd14)) begin
        n_bad++;
        $display("FAIL max_alt: rdy=%b dout=%h idx=%0d want 1/0000f/14", bus.rdy, bus.dout, bus.dout_idx);
      end
      if (pass == 1 && (bus.rdy !== 1'b1 || bus.dout !== 17'h1FFF0 || bus.dout_idx !== 4'd15)) begin
        n_bad++;
        $display("FAIL min_alt: rdy=%b dout=%h idx=%0d want 1/1fff0/15", bus.rdy, bus.dout, bus.dout_idx);
      end
      put(1'b0, 0);
      n_cmp++;
      if (bus.rdy !== 1'b0 || bus.busy !== 1'b0 || rdy_cnt - base != 1) begin
        n_bad++;
        $display("FAIL rdy_pulse: rdy=%b busy=%b pulses=%0d want 0/0/1", bus.rdy, bus.busy, rdy_cnt - base);
      end
    end
  endtask

  task automatic test_range_peak();
    for (int pass = 0; pass < 2; pass++) begin
      bus.mode = (pass == 0) ? 2'b10 : 2'b11;
      for (int i = 0; i < 16; i++) put(1'b1, (i % 2 == 0) ? (i + 1) : -(i + 1));
      n_cmp++;
      if (pass == 0 && (bus.dout !== 17'd31 || bus.dout_idx !== 4'd0)) begin
        n_bad++; $display("FAIL range_alt: dout=%h idx=%0d want 0001f/0", bus.dout, bus.dout_idx);
      end
      if (pass == 1 && (bus.dout !== 17'd16 || bus.dout_idx !== 4'd15)) begin
        n_bad++; $display("FAIL peak_alt: dout=%h idx=%0d want 00010/15", bus.dout, bus.dout_idx);
      end
      put(1'b0, 0);
    end
  endtask

  task automatic test_reset_mid_block();
    int base;
    bus.mode = 2'b00;
    for (int i = 0; i < 7; i++) put(1'b1, 1000 + i);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.dout !== 17'd0 || bus.dout_idx !== 4'd0 || bus.rdy !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: dout=%h idx=%0d rdy=%b busy=%b want 0/0/0/0",
               bus.dout, bus.dout_idx, bus.rdy, bus.busy);
    end
    bus.din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    base = rdy_cnt;
    for (int i = 0; i < 16; i++) put(1'b1, 3 * i - 20);
    put(1'b0, 0);
    n_cmp++;
    if (bus.dout !== 17'd25 || bus.dout_idx !== 4'd15 || rdy_cnt - base != 1) begin
      n_bad++;
      $display("FAIL post_reset_block: dout=%h idx=%0d pulses=%0d want 00019/15/1",
               bus.dout, bus.dout_idx, rdy_cnt - base);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int k;
    base = rdy_cnt;
    bus.mode = 2'b00;
    for (int i = 0; i < 16; i++) put(1'b1, 5);
    n_cmp++;
    if (bus.rdy !== 1'b1 || bus.dout !== 17'd5 || bus.dout_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL b2b_block_a: rdy=%b dout=%h idx=%0d want 1/00005/0", bus.rdy, bus.dout, bus.dout_idx);
    end
    k = 0;
    for (int c = 0; c < 32; c++) begin
      if (c == 9) bus.mode = 2'b01;
      if (c % 2 == 0) begin
        put(1'b1, k);
        k++;
      end else begin
        put(1'b0, 77);
      end
      if (c == 5) begin
        n_cmp++;
        if (bus.busy !== 1'b1) begin
          n_bad++; $display("FAIL busy_gap: got %b want 1", bus.busy);
        end
      end
      if (c == 30) begin
        n_cmp++;
        if (bus.rdy !== 1'b1 || bus.dout !== 17'd15 || bus.dout_idx !== 4'd15) begin
          n_bad++;
          $display("FAIL b2b_block_b: rdy=%b dout=%h idx=%0d want 1/0000f/15",
                   bus.rdy, bus.dout, bus.dout_idx);
        end
      end
    end
    bus.mode = 2'b00;
    n_cmp++;
    if (rdy_cnt - base != 2 || bus.dout !== 17'd15) begin
      n_bad++;
      $display("FAIL b2b_pulses: pulses=%0d dout=%h want 2/0000f", rdy_cnt - base, bus.dout);
    end
  endtask

  task automatic test_extremes();
    for (int pass = 0; pass < 2; pass++) begin
      bus.mode = (pass == 0) ? 2'b10 : 2'b11;
      for (int i = 0; i < 16; i++) put(1'b1, (i == 3) ? -32768 : (i == 9) ? 32767 : 0);
      n_cmp++;
      if (pass == 0 && (bus.dout !== 17'h0FFFF || bus.dout_idx !== 4'd0)) begin
        n_bad++; $display("FAIL range_extreme: dout=%h idx=%0d want 0ffff/0", bus.dout, bus.dout_idx);
      end
      if (pass == 1 && (bus.dout !== 17'h08000 || bus.dout_idx !== 4'd3)) begin
        n_bad++; $display("FAIL peak_extreme: dout=%h idx=%0d want 08000/3", bus.dout, bus.dout_idx);
      end
    end
    bus.mode = 2'b11;
    for (int i = 0; i < 16; i++) put(1'b1, (i == 2) ? -5 : (i == 6) ? 5 : 0);
    n_cmp++;
    if (bus.dout !== 17'd5 || bus.dout_idx !== 4'd2) begin
      n_bad++; $display("FAIL peak_tie: dout=%h idx=%0d want 00005/2", bus.dout, bus.dout_idx);
    end
    bus.mode = 2'b01;
    for (int i = 0; i < 16; i++) put(1'b1, (i == 4 || i == 12) ? -9 : 1);
    n_cmp++;
    if (bus.dout !== 17'h1FFF7 || bus.dout_idx !== 4'd4) begin
      n_bad++; $display("FAIL min_tie: dout=%h idx=%0d want 1fff7/4", bus.dout, bus.dout_idx);
    end
    put(1'b0, 0);
  endtask

  task automatic test_clear();
    int base;
    base = rdy_cnt;
    bus.mode = 2'b00;
    for (int i = 0; i < 10; i++) put(1'b1, 500 + i);
    bus.clear = 1'b1;
    put(1'b1, 900);
    bus.clear = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.rdy !== 1'b0 || bus.dout !== 17'h1FFF7 || bus.dout_idx !== 4'd4) begin
      n_bad++;
      $display("FAIL clear_mid: busy=%b rdy=%b dout=%h idx=%0d want 0/0/1fff7/4",
               bus.busy, bus.rdy, bus.dout, bus.dout_idx);
    end
    bus.mode = 2'b01;
    for (int i = 0; i < 16; i++) put(1'b1, (i == 11) ? -7 : i);
    n_cmp++;
    if (bus.rdy !== 1'b1 || bus.dout !== 17'h1FFF9 || bus.dout_idx !== 4'd11) begin
      n_bad++;
      $display("FAIL after_clear: rdy=%b dout=%h idx=%0d want 1/1fff9/11", bus.rdy, bus.dout, bus.dout_idx);
    end
    bus.mode = 2'b00;
    for (int i = 0; i < 15; i++) put(1'b1, 40);
    bus.clear = 1'b1;
    put(1'b1, 41);
    bus.clear = 1'b0;
    put(1'b0, 0);
    n_cmp++;
    if (rdy_cnt - base != 1 || bus.dout !== 17'h1FFF9 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_last: pulses=%0d dout=%h busy=%b want 1/1fff9/0", rdy_cnt - base, bus.dout, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_max_min();
    test_range_peak();
    test_reset_mid_block();
    test_back_to_back();
    test_extremes();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maxmin_window.md
Name: maxmin_window

Overview:
- Parametrised block-statistics unit for a signed sample stream. Collects BLOCK_LEN valid samples and reports one of four statistics per block: max, min, range (max-min) or peak magnitude. Also reports the in-block index of the winning sample.
- Sits after the sample source in the accumulator/statistics datapath. Runs back-to-back blocks with no dead cycles.

Parameters:
- WIDTH, 16, sample width in bits (two's complement when SIGNED=1).
- BLOCK_LEN, 16, samples per block; legal range 2..65536.
- SIGNED, 1, 1 = signed compare, 0 = unsigned compare. Mode 11 is illegal when SIGNED=0.
- IDX_W, $clog2(BLOCK_LEN), derived localparam; index width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- din_valid  in  1  din is a sample this cycle.
- din  in  WIDTH  input sample.
- mode  in  2  statistic select: 00 max, 01 min, 10 range, 11 peak |x|.
- clear  in  1  synchronous abort of the current partial block.
- dout  out  WIDTH+1  result; sign-extended for max/min, unsigned for range and peak.
- dout_idx  out  IDX_W  index (0-based) of the max, min or peak sample. 0 in range mode.
- rdy  out  1  one-cycle pulse: dout/dout_idx updated this cycle.
- busy  out  1  high while a block is partially collected.

Behaviour:
- Reset (rst=0, asynchronous): dout=0, dout_idx=0, rdy=0, busy=0, count=0, state=IDLE. Takes effect immediately regardless of clk. A partial block is discarded with no rdy.
- FSM has two states, IDLE and ACC.
- IDLE to ACC: on din_valid=1 (and clear=0).
  - run_max = run_min = din; max_idx = min_idx = 0.
  - run_pk = |din|; pk_idx = 0.
  - mode is latched into mode_q; count = 1.
  - mode changes mid-block are ignored until the next block.
- ACC, on each din_valid=1:
  - Compare din against the running values; count increments.
  - Strict compare, so on a tie the earliest index is kept.
- ACC, when din_valid=1 and count == BLOCK_LEN-1 (last sample):
  - The final result includes that sample and is registered into dout/dout_idx at the same edge.
  - rdy=1 for exactly the next cycle.
  - State goes to IDLE, count=0.
  - If din_valid=1 in the following cycle, that sample is index 0 of the next block. Zero-bubble throughput is required.
- din_valid=0 in ACC: hold all state; gaps of any length are allowed.
- dout and dout_idx hold their values between rdy pulses.
- Latency: rdy is asserted in the cycle after the clock edge that accepts the last sample.
- Arithmetic:
  - range = max - min, computed in WIDTH+1 bits, never overflows. Example: WIDTH=16, max=32767, min=-32768 gives 65535.
  - peak = |x| in WIDTH+1 bits; -2^(WIDTH-1) maps to 2^(WIDTH-1). On equal magnitude the earliest index wins; +5 and -5 are equal.
  - In unsigned mode dout is zero-extended.
- clear=1 (synchronous):
  - State goes to IDLE, count=0, busy=0 at the next edge.
  - A din_valid sample in the same cycle is dropped.
  - dout and dout_idx are untouched; no rdy.
  - clear on the cycle of the last sample also wins: no rdy.
- busy = (state == ACC), registered.
- Wrap-around: count never exceeds BLOCK_LEN-1.
- BLOCK_LEN a power of two: IDX_W bits hold indices 0..BLOCK_LEN-1 exactly.

Test Plan:
- Reset mid-block: 7 samples, then rst=0 asynchronously between clock edges. Required: outputs 0 immediately. After release, a full 16-sample block yields exactly one rdy with only the new block's data.
- Default params, mode=00, gapless stream din = 1,-2,3,-4,...,15,-16. Required: rdy pulses one cycle after the 16th sample; dout=15, dout_idx=14. Rerun with mode=01: dout=-16 (17'h1FFF0), dout_idx=15.
- Same stream, mode=10, then mode=11. Required: mode 10 gives dout=31, dout_idx=0. Mode 11 gives dout=16, dout_idx=15.
- Back-to-back blocks with no gap: block A is all 5; block B is 0..15 with din_valid toggling 1,0,1,0. Required, mode 00:
  - Block A: dout=5, dout_idx=0 (tie keeps first index).
  - Block B: dout=15, dout_idx=15.
  - Exactly two rdy pulses.
  - Changing mode mid-block B has no effect.
- Extremes, mode 10 then 11: block containing -32768 and 32767. Required: range 65535 with no overflow; peak 32768 at the index of -32768.
- Clear: 10 samples, then clear=1 with din_valid=1. Required: busy drops next cycle, no rdy, dout holds the previous value. The next 16 samples give a correct result at indices 0..15.
